// File: rtl/tag_seq_pkg.sv
// Shared types for the tag window sequencer: FSM state encoding and the
// configuration snapshot captured when a run is armed.
package tag_seq_pkg;

  localparam int unsigned SEQ_TIME_W = 64;
  localparam int unsigned SEQ_CH_W   = 5;
  localparam int unsigned SEQ_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    OPEN    = 2'd2,
    HOLDOFF = 2'd3
  } seq_state_t;

  // Field widths follow the package widths, which the top-level parameter defaults also use.
  typedef struct packed {
    logic [SEQ_CH_W-1:0]   start_ch;
    logic                  start_rising;
    logic                  stop_en;
    logic [SEQ_CH_W-1:0]   stop_ch;
    logic [SEQ_TIME_W-1:0] window_len;
    logic [SEQ_TIME_W-1:0] holdoff_len;
    logic [SEQ_CNT_W-1:0]  num_windows;
  } seq_cfg_t;

endpackage

// File: rtl/tag_window_sequencer.sv
// Acquisition window sequencer on the decoded tag stream: opens on a start edge, forwards
// tags with window-relative time, closes on duration or stop edge, repeats with holdoff.
module tag_window_sequencer
  import tag_seq_pkg::*;
#(
  parameter int unsigned TIME_WIDTH = SEQ_TIME_W,
  parameter int unsigned CH_WIDTH   = SEQ_CH_W,
  parameter int unsigned CNT_WIDTH  = SEQ_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctl_arm,
  input  logic                  ctl_abort,
  input  logic [CH_WIDTH-1:0]   cfg_start_ch,
  input  logic                  cfg_start_rising,
  input  logic                  cfg_stop_en,
  input  logic [CH_WIDTH-1:0]   cfg_stop_ch,
  input  logic [TIME_WIDTH-1:0] cfg_window_len,
  input  logic [TIME_WIDTH-1:0] cfg_holdoff_len,
  input  logic [CNT_WIDTH-1:0]  cfg_num_windows,
  input  logic                  tag_valid,
  input  logic [CH_WIDTH-1:0]   tag_channel,
  input  logic                  tag_rising,
  input  logic [TIME_WIDTH-1:0] tag_time,
  output logic                  out_valid,
  output logic [CH_WIDTH-1:0]   out_channel,
  output logic                  out_rising,
  output logic [TIME_WIDTH-1:0] out_time_rel,
  output logic [CNT_WIDTH-1:0]  out_window_idx,
  output logic                  busy,
  output logic                  window_open,
  output logic                  win_done,
  output logic [CNT_WIDTH-1:0]  win_tag_count,
  output logic                  run_done,
  output logic                  run_aborted,
  output logic                  err_order
);

  seq_state_t state, state_n;
  seq_cfg_t   cfg_q, cfg_in;

  logic [TIME_WIDTH-1:0] t0, t_end, h_end, last_time;
  logic [CNT_WIDTH-1:0]  window_idx, tag_count, idx_inc;

  logic abort_act, arm_act, tv;
  logic start_hit, holdoff_clear, eval_start, zero_len;
  logic time_close, stop_close, close, fwd_in_window, fwd, last_window;
  logic [TIME_WIDTH-1:0] close_base;

  logic                  out_valid_n, out_rising_n;
  logic [CH_WIDTH-1:0]   out_channel_n;
  logic [TIME_WIDTH-1:0] out_time_rel_n;
  logic                  win_done_n, run_done_n, run_aborted_n, err_order_n;
  logic [CNT_WIDTH-1:0]  win_tag_count_n;

  assign cfg_in = '{
    start_ch:     cfg_start_ch,
    start_rising: cfg_start_rising,
    stop_en:      cfg_stop_en,
    stop_ch:      cfg_stop_ch,
    window_len:   cfg_window_len,
    holdoff_len:  cfg_holdoff_len,
    num_windows:  cfg_num_windows
  };

  // Abort beats everything, including an arm in the same cycle and any tag in flight.
  assign abort_act = ctl_abort && (state != IDLE);
  assign arm_act   = ctl_arm && !ctl_abort && (state == IDLE);
  assign tv        = tag_valid && !abort_act;

  assign start_hit     = tv && (tag_channel == cfg_q.start_ch) && (tag_rising == cfg_q.start_rising);
  assign holdoff_clear = tv && (tag_time >= h_end);
  // A tag that ends the holdoff is also judged as a start candidate in the same cycle.
  assign eval_start    = start_hit && ((state == ARMED) || ((state == HOLDOFF) && holdoff_clear));
  assign zero_len      = (cfg_q.window_len == '0);

  assign time_close    = tv && (state == OPEN) && (tag_time >= t_end);
  assign stop_close    = tv && (state == OPEN) && !time_close && cfg_q.stop_en &&
                         (tag_channel == cfg_q.stop_ch);
  assign fwd_in_window = tv && (state == OPEN) && !time_close && !stop_close;
  assign fwd           = fwd_in_window || (eval_start && !zero_len);
  assign close         = time_close || stop_close || (eval_start && zero_len);

  assign idx_inc     = window_idx + CNT_WIDTH'(1);
  assign last_window = (cfg_q.num_windows != '0) && (idx_inc == cfg_q.num_windows);
  assign close_base  = time_close ? t_end : tag_time;

  assign busy           = (state != IDLE);
  assign window_open    = (state == OPEN);
  assign out_window_idx = window_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (arm_act) state_n = ARMED;
      ARMED, HOLDOFF: begin
        if (eval_start) begin
          if (!zero_len)        state_n = OPEN;
          else if (last_window) state_n = IDLE;
          else                  state_n = HOLDOFF;
        end else if ((state == HOLDOFF) && holdoff_clear) begin
          state_n = ARMED;
        end
      end
      OPEN: if (close) state_n = last_window ? IDLE : HOLDOFF;
      default: state_n = IDLE;
    endcase
    if (abort_act) state_n = IDLE;
  end

  always_comb begin
    out_valid_n    = fwd;
    out_channel_n  = fwd ? tag_channel : '0;
    out_rising_n   = fwd && tag_rising;
    out_time_rel_n = '0;
    if (fwd_in_window) out_time_rel_n = tag_time - t0;

    win_done_n      = close || (abort_act && (state == OPEN));
    win_tag_count_n = win_tag_count;
    if (eval_start && zero_len) win_tag_count_n = '0;
    else if (win_done_n)        win_tag_count_n = tag_count;

    run_done_n = abort_act || (close && last_window);

    run_aborted_n = run_aborted;
    if (arm_act)   run_aborted_n = 1'b0;
    if (abort_act) run_aborted_n = 1'b1;

    err_order_n = err_order;
    if (arm_act)                                        err_order_n = 1'b0;
    else if (fwd_in_window && (tag_time < last_time))   err_order_n = 1'b1;
  end

  // NOTE: the snapshot and timing registers are reset too, so no stale config survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      t0         <= '0;
      t_end      <= '0;
      h_end      <= '0;
      last_time  <= '0;
      window_idx <= '0;
      tag_count  <= '0;
    end else begin
      if (arm_act) begin
        cfg_q      <= cfg_in;
        window_idx <= '0;
      end
      if (eval_start) begin
        t0        <= tag_time;
        t_end     <= tag_time + cfg_q.window_len;
        tag_count <= zero_len ? '0 : CNT_WIDTH'(1);
        last_time <= tag_time;
      end else if (fwd_in_window) begin
        tag_count <= (&tag_count) ? tag_count : tag_count + CNT_WIDTH'(1);
        last_time <= tag_time;
      end
      if (close) begin
        window_idx <= idx_inc;
        h_end      <= close_base + cfg_q.holdoff_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_channel   <= '0;
      out_rising    <= 1'b0;
      out_time_rel  <= '0;
      win_done      <= 1'b0;
      win_tag_count <= '0;
      run_done      <= 1'b0;
      run_aborted   <= 1'b0;
      err_order     <= 1'b0;
    end else begin
      out_valid     <= out_valid_n;
      out_channel   <= out_channel_n;
      out_rising    <= out_rising_n;
      out_time_rel  <= out_time_rel_n;
      win_done      <= win_done_n;
      win_tag_count <= win_tag_count_n;
      run_done      <= run_done_n;
      run_aborted   <= run_aborted_n;
      err_order     <= err_order_n;
    end
  end

endmodule
